// File: rtl/umi_arb_pkg.sv
// Shared definitions for UMI arbiters: command bit positions and index sizing.
package umi_arb_pkg;

  localparam int UMI_EOM_BIT = 22;

  // Index width for an N-way arbiter; never narrower than one bit so N=1 still has a port.
  function automatic int umi_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/umi_rr_grant.sv
// Combinational round-robin grant with message lock: one-hot grant plus encoded index.
module umi_rr_grant
  import umi_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = umi_idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_lock,
  input  logic [IW-1:0] i_lock_idx,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_grant_vld
);

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= N) ? (s - N) : s;
  endfunction

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    if (i_lock) begin
      for (int i = 0; i < N; i++) begin
        if ((i_lock_idx == IW'(i)) && i_req[i]) begin
          o_grant[i]  = 1'b1;
          o_grant_idx = IW'(i);
          o_grant_vld = 1'b1;
        end
      end
    end else begin
      // Walk from farthest to nearest so the candidate closest to ptr overwrites the rest.
      for (int k = N - 1; k >= 0; k--) begin
        if (i_req[wrap_idx(int'(i_ptr), k)]) begin
          o_grant                         = '0;
          o_grant[wrap_idx(int'(i_ptr), k)] = 1'b1;
          o_grant_idx                     = IW'(wrap_idx(int'(i_ptr), k));
          o_grant_vld                     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/umi_rr_arbiter.sv
// N-to-1 UMI round-robin arbiter with message locking and a single registered output stage.
module umi_rr_arbiter
  import umi_arb_pkg::*;
#(
  parameter  int N  = 2,
  parameter  int DW = 256,
  parameter  int CW = 32,
  parameter  int AW = 64,
  localparam int IW = umi_idx_w(N)
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready,
  output logic [IW-1:0]   umi_out_src_idx
);

  logic [IW-1:0] r_ptr;
  logic          r_lock;
  logic [IW-1:0] r_lock_idx;

  logic          r_out_valid;
  logic [CW-1:0] r_out_cmd;
  logic [AW-1:0] r_out_dstaddr;
  logic [AW-1:0] r_out_srcaddr;
  logic [DW-1:0] r_out_data;
  logic [IW-1:0] r_out_src_idx;

  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_grant_idx;
  logic          w_grant_vld;
  logic          w_can_load;
  logic          w_accept;
  logic          w_eom;
  logic [IW-1:0] w_next_ptr;
  logic [CW-1:0] w_cmd;
  logic [AW-1:0] w_dstaddr;
  logic [AW-1:0] w_srcaddr;
  logic [DW-1:0] w_data;

  umi_rr_grant #(
    .N (N)
  ) u_grant (
    .i_req       (umi_in_valid),
    .i_ptr       (r_ptr),
    .i_lock      (r_lock),
    .i_lock_idx  (r_lock_idx),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  assign w_can_load   = !r_out_valid || umi_out_ready;
  assign w_accept     = w_can_load && w_grant_vld;
  assign umi_in_ready = w_grant & {N{w_can_load}};

  // Grant is one-hot, so an AND-OR field mux is sufficient.
  always_comb begin
    w_cmd     = '0;
    w_dstaddr = '0;
    w_srcaddr = '0;
    w_data    = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_cmd     = umi_in_cmd[i*CW +: CW];
        w_dstaddr = umi_in_dstaddr[i*AW +: AW];
        w_srcaddr = umi_in_srcaddr[i*AW +: AW];
        w_data    = umi_in_data[i*DW +: DW];
      end
    end
  end

  assign w_eom      = w_cmd[UMI_EOM_BIT];
  assign w_next_ptr = (w_grant_idx == IW'(N - 1)) ? '0 : (w_grant_idx + IW'(1));

  // Arbitration state: the pointer only advances when a message completes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_accept) begin
      if (w_eom) begin
        r_lock <= 1'b0;
        r_ptr  <= w_next_ptr;
      end else begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_out_valid   <= 1'b0;
      r_out_cmd     <= '0;
      r_out_dstaddr <= '0;
      r_out_srcaddr <= '0;
      r_out_data    <= '0;
      r_out_src_idx <= '0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_cmd     <= w_cmd;
      r_out_dstaddr <= w_dstaddr;
      r_out_srcaddr <= w_srcaddr;
      r_out_data    <= w_data;
      r_out_src_idx <= w_grant_idx;
    end else if (w_can_load) begin
      r_out_valid <= 1'b0;
    end
  end

  assign umi_out_valid   = r_out_valid;
  assign umi_out_cmd     = r_out_cmd;
  assign umi_out_dstaddr = r_out_dstaddr;
  assign umi_out_srcaddr = r_out_srcaddr;
  assign umi_out_data    = r_out_data;
  assign umi_out_src_idx = r_out_src_idx;

endmodule

// File: tb/tb_umi_rr_arbiter.sv
// Directed bench for umi_rr_arbiter: a 2-input instance driven from a vector table and a 3-input instance for pointer wrap.
module tb_umi_rr_arbiter;

  localparam int N  = 2;
  localparam int DW = 256;
  localparam int CW = 32;
  localparam int AW = 64;

  localparam int N3  = 3;
  localparam int DW3 = 32;
  localparam int CW3 = 32;
  localparam int AW3 = 16;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic [N-1:0]    in_valid;
  logic [N*CW-1:0] in_cmd;
  logic [N*AW-1:0] in_dst;
  logic [N*AW-1:0] in_src;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [CW-1:0]   out_cmd;
  logic [AW-1:0]   out_dst;
  logic [AW-1:0]   out_src;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic [0:0]      out_idx;

  logic [N3-1:0]     in3_valid;
  logic [N3*CW3-1:0] in3_cmd;
  logic [N3*AW3-1:0] in3_dst;
  logic [N3*AW3-1:0] in3_src;
  logic [N3*DW3-1:0] in3_data;
  logic [N3-1:0]     in3_ready;
  logic              out3_valid;
  logic [CW3-1:0]    out3_cmd;
  logic [AW3-1:0]    out3_dst;
  logic [AW3-1:0]    out3_src;
  logic [DW3-1:0]    out3_data;
  logic              out3_ready;
  logic [1:0]        out3_idx;

  umi_rr_arbiter #(.N(N), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (in_valid),
    .umi_in_cmd      (in_cmd),
    .umi_in_dstaddr  (in_dst),
    .umi_in_srcaddr  (in_src),
    .umi_in_data     (in_data),
    .umi_in_ready    (in_ready),
    .umi_out_valid   (out_valid),
    .umi_out_cmd     (out_cmd),
    .umi_out_dstaddr (out_dst),
    .umi_out_srcaddr (out_src),
    .umi_out_data    (out_data),
    .umi_out_ready   (out_ready),
    .umi_out_src_idx (out_idx)
  );

  umi_rr_arbiter #(.N(N3), .DW(DW3), .CW(CW3), .AW(AW3)) dut3 (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (in3_valid),
    .umi_in_cmd      (in3_cmd),
    .umi_in_dstaddr  (in3_dst),
    .umi_in_srcaddr  (in3_src),
    .umi_in_data     (in3_data),
    .umi_in_ready    (in3_ready),
    .umi_out_valid   (out3_valid),
    .umi_out_cmd     (out3_cmd),
    .umi_out_dstaddr (out3_dst),
    .umi_out_srcaddr (out3_src),
    .umi_out_data    (out3_data),
    .umi_out_ready   (out3_ready),
    .umi_out_src_idx (out3_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Other fields are derived from the data byte so passthrough of every field can be checked.
  task automatic set_in(input int i, input logic v, input logic eom, input logic [7:0] d);
    logic [CW-1:0] c;
    c        = '0;
    c[7:0]   = d;
    c[22]    = eom;
    in_valid[i]            = v;
    in_cmd[i*CW +: CW]     = c;
    in_dst[i*AW +: AW]     = 64'(d) * 64'd3;
    in_src[i*AW +: AW]     = ~64'(d);
    in_data[i*DW +: DW]    = DW'(d);
  endtask

  task automatic set3(input int i, input logic v, input logic [7:0] d);
    logic [CW3-1:0] c;
    c      = '0;
    c[7:0] = d;
    c[22]  = 1'b1;
    in3_valid[i]           = v;
    in3_cmd[i*CW3 +: CW3]  = c;
    in3_dst[i*AW3 +: AW3]  = AW3'(d) + AW3'(16'h100);
    in3_src[i*AW3 +: AW3]  = '0;
    in3_data[i*DW3 +: DW3] = DW3'(d);
  endtask

  typedef struct {
    logic [1:0] v;
    logic [1:0] e;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic [1:0] ir;
    logic       ov;
    logic [7:0] od;
    logic       oi;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] e, input logic [7:0] d0,
                              input logic [7:0] d1, input logic rdy, input logic [1:0] ir,
                              input logic ov, input logic [7:0] od, input logic oi);
    vec_t t;
    t.v = v; t.e = e; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
    t.ir = ir; t.ov = ov; t.od = od; t.oi = oi;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    // Single stream from input 0
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0));
    tbl.push_back(mk(2'b01, 2'b01, 8'h11, 8'h00, 1, 2'b01, 0, 8'h00, 0));
    tbl.push_back(mk(2'b01, 2'b01, 8'h22, 8'h00, 1, 2'b01, 1, 8'h11, 0));
    tbl.push_back(mk(2'b01, 2'b01, 8'h33, 8'h00, 1, 2'b01, 1, 8'h22, 0));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 8'h33, 0));
    // Fairness: ptr is 1 after input 0 finished
    tbl.push_back(mk(2'b11, 2'b11, 8'h41, 8'h51, 1, 2'b10, 0, 8'h00, 0));
    tbl.push_back(mk(2'b11, 2'b11, 8'h41, 8'h52, 1, 2'b01, 1, 8'h51, 1));
    tbl.push_back(mk(2'b11, 2'b11, 8'h42, 8'h52, 1, 2'b10, 1, 8'h41, 0));
    tbl.push_back(mk(2'b11, 2'b11, 8'h42, 8'h53, 1, 2'b01, 1, 8'h52, 1));
    tbl.push_back(mk(2'b10, 2'b10, 8'h00, 8'h54, 1, 2'b10, 1, 8'h42, 0));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 8'h54, 1));
    // Message lock on input 0 while input 1 waits, including an idle cycle inside the message
    tbl.push_back(mk(2'b11, 2'b10, 8'hA1, 8'hD1, 1, 2'b01, 0, 8'h00, 0));
    tbl.push_back(mk(2'b11, 2'b10, 8'hB1, 8'hD1, 1, 2'b01, 1, 8'hA1, 0));
    tbl.push_back(mk(2'b10, 2'b10, 8'h00, 8'hD1, 1, 2'b00, 1, 8'hB1, 0));
    tbl.push_back(mk(2'b11, 2'b11, 8'hC1, 8'hD1, 1, 2'b01, 0, 8'h00, 0));
    tbl.push_back(mk(2'b10, 2'b10, 8'h00, 8'hD1, 1, 2'b10, 1, 8'hC1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 8'hD1, 1));
    // Backpressure: 0x55 held for 5 cycles, then drain and load in the same cycle
    tbl.push_back(mk(2'b01, 2'b01, 8'h55, 8'h00, 1, 2'b01, 0, 8'h00, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(2'b11, 2'b11, 8'h66, 8'h77, 0, 2'b00, 1, 8'h55, 0));
    tbl.push_back(mk(2'b11, 2'b11, 8'h66, 8'h77, 1, 2'b10, 1, 8'h55, 0));
    tbl.push_back(mk(2'b01, 2'b01, 8'h66, 8'h00, 1, 2'b01, 1, 8'h77, 1));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 8'h66, 0));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0));
    // Empty output accepts even with out_ready low
    tbl.push_back(mk(2'b01, 2'b01, 8'h88, 8'h00, 0, 2'b01, 0, 8'h00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 0, 2'b00, 1, 8'h88, 0));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 8'h88, 0));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0));

    nreset     = 1'b0;
    out_ready  = 1'b1;
    out3_ready = 1'b1;
    in_valid = '0; in_cmd = '0; in_dst = '0; in_src = '0; in_data = '0;
    in3_valid = '0; in3_cmd = '0; in3_dst = '0; in3_src = '0; in3_data = '0;

    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data",  out_data[63:0], 64'd0);
    check("reset out_cmd",   64'(out_cmd),   64'd0);
    check("reset src_idx",   64'(out_idx),   64'd0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < tbl.size(); r++) begin
      set_in(0, tbl[r].v[0], tbl[r].e[0], tbl[r].d0);
      set_in(1, tbl[r].v[1], tbl[r].e[1], tbl[r].d1);
      out_ready = tbl[r].rdy;
      @(negedge clk);
      check($sformatf("row%0d in_ready", r),  64'(in_ready),  64'(tbl[r].ir));
      check($sformatf("row%0d out_valid", r), 64'(out_valid), 64'(tbl[r].ov));
      if (tbl[r].ov) begin
        check($sformatf("row%0d out_data", r), out_data[63:0],     64'(tbl[r].od));
        check($sformatf("row%0d src_idx", r),  64'(out_idx),       64'(tbl[r].oi));
        check($sformatf("row%0d out_cmd", r),  64'(out_cmd[7:0]),  64'(tbl[r].od));
        check($sformatf("row%0d dstaddr", r),  out_dst,            64'(tbl[r].od) * 64'd3);
        check($sformatf("row%0d srcaddr", r),  out_src,            ~64'(tbl[r].od));
      end
      @(posedge clk); #1;
    end

    // Reset in the middle of a message from input 1 (ptr is 1 here)
    set_in(0, 1'b0, 1'b1, 8'h00);
    set_in(1, 1'b1, 1'b0, 8'h99);
    out_ready = 1'b1;
    @(negedge clk);
    check("mid-msg in_ready", 64'(in_ready), 64'd2);
    @(posedge clk); #1;
    set_in(0, 1'b1, 1'b1, 8'hA5);
    set_in(1, 1'b1, 1'b1, 8'hB5);
    out_ready = 1'b0;
    @(negedge clk);
    check("mid-msg out_valid", 64'(out_valid), 64'd1);
    check("mid-msg out_data",  out_data[63:0], 64'h99);
    check("mid-msg src_idx",   64'(out_idx),   64'd1);
    #2 nreset = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset out_data",  out_data[63:0], 64'd0);
    check("async reset src_idx",   64'(out_idx),   64'd0);
    nreset    = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post-reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b1, 8'h00);
    set_in(1, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    check("post-reset out_valid", 64'(out_valid), 64'd1);
    check("post-reset out_data",  out_data[63:0], 64'hA5);
    check("post-reset src_idx",   64'(out_idx),   64'd0);
    @(posedge clk); #1;

    // Three inputs: pointer must wrap from 2 back to 0
    begin
      logic [2:0] v3  [6];
      logic [7:0] d3  [6][3];
      logic [2:0] ir3 [6];
      logic       ov3 [6];
      logic [7:0] od3 [6];
      logic [1:0] oi3 [6];
      v3[0] = 3'b111; d3[0] = '{8'h10, 8'h20, 8'h30}; ir3[0] = 3'b001; ov3[0] = 0; od3[0] = 8'h00; oi3[0] = 2'd0;
      v3[1] = 3'b111; d3[1] = '{8'h11, 8'h20, 8'h30}; ir3[1] = 3'b010; ov3[1] = 1; od3[1] = 8'h10; oi3[1] = 2'd0;
      v3[2] = 3'b111; d3[2] = '{8'h11, 8'h21, 8'h30}; ir3[2] = 3'b100; ov3[2] = 1; od3[2] = 8'h20; oi3[2] = 2'd1;
      v3[3] = 3'b011; d3[3] = '{8'h11, 8'h21, 8'h00}; ir3[3] = 3'b001; ov3[3] = 1; od3[3] = 8'h30; oi3[3] = 2'd2;
      v3[4] = 3'b011; d3[4] = '{8'h12, 8'h21, 8'h00}; ir3[4] = 3'b010; ov3[4] = 1; od3[4] = 8'h11; oi3[4] = 2'd0;
      v3[5] = 3'b000; d3[5] = '{8'h00, 8'h00, 8'h00}; ir3[5] = 3'b000; ov3[5] = 1; od3[5] = 8'h21; oi3[5] = 2'd1;
      for (int s = 0; s < 6; s++) begin
        for (int i = 0; i < N3; i++) set3(i, v3[s][i], d3[s][i]);
        @(negedge clk);
        check($sformatf("wrap%0d in_ready", s),  64'(in3_ready),  64'(ir3[s]));
        check($sformatf("wrap%0d out_valid", s), 64'(out3_valid), 64'(ov3[s]));
        if (ov3[s]) begin
          check($sformatf("wrap%0d out_data", s), 64'(out3_data),      64'(od3[s]));
          check($sformatf("wrap%0d src_idx", s),  64'(out3_idx),       64'(oi3[s]));
          check($sformatf("wrap%0d dstaddr", s),  64'(out3_dst),       64'(od3[s]) + 64'h100);
          check($sformatf("wrap%0d cmd", s),      64'(out3_cmd[7:0]),  64'(od3[s]));
          check($sformatf("wrap%0d srcaddr", s),  64'(out3_src),       64'd0);
        end
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/umi_rr_arbiter.md
Name: umi_rr_arbiter

Overview:
- Merges N independent UMI request streams into one UMI output stream.
- Fair round-robin arbitration that never interleaves a multi-transaction message: grant locks to an input until its EOM transaction is accepted.
- Sits upstream of a single UMI consumer, e.g. several hosts sharing one `umi_splitter` request path or one switchboard `tx` queue.
- One registered output stage: 1-cycle latency, full throughput.

Parameters:
- N, 2, number of UMI inputs (>=1).
- DW, 256, UMI data width.
- CW, 32, UMI command width.
- AW, 64, UMI address width.

Ports:
- clk  input  1  clock.
- nreset  input  1  asynchronous active-low reset.
- umi_in_valid  input  N  per-input valid.
- umi_in_cmd  input  N*CW  cmds; input i occupies [i*CW +: CW].
- umi_in_dstaddr  input  N*AW  destination addresses, same packing.
- umi_in_srcaddr  input  N*AW  source addresses, same packing.
- umi_in_data  input  N*DW  data, same packing.
- umi_in_ready  output  N  per-input ready.
- umi_out_valid  output  1  output valid.
- umi_out_cmd  output  CW  output cmd.
- umi_out_dstaddr  output  AW  output dstaddr.
- umi_out_srcaddr  output  AW  output srcaddr.
- umi_out_data  output  DW  output data.
- umi_out_ready  input  1  output ready.
- umi_out_src_idx  output  max(1,$clog2(N))  input index of the held output transaction.

Behaviour:
- Clock and reset: single clock `clk`; `nreset` is asynchronous, active-low.
- Reset values: umi_out_valid=0; out cmd/dstaddr/srcaddr/data/src_idx=0; rr pointer ptr=0; lock=0; lock_idx=0.
- Handshake: transfer occurs when valid && ready at the clk rising edge.
  - Valid never depends on ready.
  - umi_out_* are held stable while umi_out_valid && !umi_out_ready.
- Load condition: can_load = !umi_out_valid || umi_out_ready.
- Grant is combinational and one-hot (or zero):
  - If lock=1: grant = lock_idx if umi_in_valid[lock_idx], else none. Other inputs wait even if the locked input idles.
  - If lock=0: first valid input searching ptr, ptr+1, ..., wrapping modulo N.
- umi_in_ready[i] = can_load && grant[i]. At most one ready bit is high per cycle. Ready may depend on umi_in_valid.
- On accept from input g:
  - Output registers load input g fields; umi_out_src_idx=g; umi_out_valid=1 next cycle.
  - cmd[22] (EOM)=0: lock=1, lock_idx=g; ptr unchanged.
  - EOM=1: lock=0; ptr=(g+1) mod N. The wrap from N-1 goes to 0; this also covers non-power-of-two N.
- No accept while can_load=1: umi_out_valid clears to 0 at the edge (output consumed or already empty).
- Latency and throughput: input accept to umi_out_valid is 1 cycle. One transaction per cycle when umi_out_ready is held 1, with no bubbles when switching inputs.
- Boundary conditions:
  - Output full and umi_out_ready=0: all umi_in_ready=0; pointer and lock frozen.
  - Simultaneous output drain and new accept in the same cycle: new data loaded, umi_out_valid stays 1.
  - N=1: pass-through register; pointer constant 0; lock tracked but irrelevant.
- Reset mid-operation: asserting nreset immediately (asynchronously) clears umi_out_valid, the output registers, lock and ptr. Any held transaction and partially sent message are discarded; the upstream source must restart the message.
- Transaction contents: no field is modified.

Decomposition:
- Shared package `umi_arb_pkg`:
  - UMI_EOM_BIT=22.
  - Function returning the index width max(1,$clog2(N)).
- Sub-module `umi_rr_grant` (parameter N): inputs req[N], ptr, lock, lock_idx; output one-hot grant[N] plus encoded index. Purely combinational; reusable by future UMI arbiters.
- Top level holds: ptr/lock registers, output stage, field mux.

Test Plan:
- Single stream: N=2; input 0 sends 3 EOM=1 txns (data 0x11, 0x22, 0x33) back-to-back, umi_out_ready=1 → out valid cycles 1-3 with data 0x11, 0x22, 0x33; src_idx=0; umi_in_ready[0]=1 every cycle.
- Fairness: both inputs continuously valid with EOM=1, ready=1 → src_idx sequence 0,1,0,1,... with no idle cycle.
- Message lock: input 0 sends EOM=0,0,1 (data A,B,C) while input 1 holds D valid from cycle 0 → output order A,B,C,D; umi_in_ready[1]=0 until C is accepted.
- Backpressure: output holding data 0x55, umi_out_ready=0 for 5 cycles while both inputs valid → out fields stable, all umi_in_ready=0. On release, 0x55 drains and the next grant loads the same cycle; no loss or duplication.
- Reset mid-message: nreset low after input 1 sends an EOM=0 txn → umi_out_valid=0 within the same cycle. After release with both inputs valid, input 0 wins first (ptr=0, lock cleared).
- Wrap-around: N=3; after input 2 accepted with EOM=1, inputs 0 and 1 valid → input 0 granted next, then 1.
